hpf_bias_cal: RTL

Clocked offset-calibration loop that generates the differential bias voltages for the downstream differential high-pass filter pair and trims them against the filter's own outputs. On request it runs an NBITS successive-approximation search on a bias DAC code. Each trial bit is settled, then majority-voted on sign(outp − outn), so the filtered differential output is driven to within one LSB of zero. It is a real-number behavioural model, with a clocked digital state machine and real-valued analog ports, and is used for the AFE front-end simulation.

---
 rtl/hpf_bias_cal.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hpf_bias_cal.sv
// Successive-approximation offset trim for a differential HPF pair: drives real-valued
// differential biases and majority-votes sign(outp - outn) to pick each DAC code bit.
module hpf_bias_cal #(
    parameter int  NBITS      = 6,
    parameter real VCM        = 0.5,
    parameter real LSB        = 0.01,
    parameter int  SETTLE_CYC = 8,
    parameter int  AVG_CNT    = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             cal_en,
    input  real              outp,
    input  real              outn,
    output real              biasp,
    output real              biasn,
    output logic [NBITS-1:0] code,
    output logic             cal_busy,
    output logic             cal_done
);

    localparam int IDX_W  = $clog2(NBITS);
    localparam int CNT_MAX = (SETTLE_CYC > AVG_CNT) ? SETTLE_CYC : AVG_CNT;
    localparam int CNT_W  = $clog2(CNT_MAX) + 1;
    localparam int VOTE_W = $clog2(AVG_CNT + 1);
    localparam int MID    = 1 << (NBITS - 1);

    localparam logic [NBITS-1:0]  MID_CODE    = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [IDX_W-1:0]  IDX_MSB     = IDX_W'(NBITS - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(AVG_CNT - 1);
    localparam logic [VOTE_W-1:0] HALF_VOTES  = VOTE_W'(AVG_CNT / 2);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETTLE = 3'd1;
    localparam logic [2:0] SAMPLE = 3'd2;
    localparam logic [2:0] DECIDE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]        state;
    logic [NBITS-1:0]  result;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_m1;
    logic [CNT_W-1:0]  cnt;
    logic [VOTE_W-1:0] votes;
    logic [NBITS-1:0]  decided_code;
    logic [NBITS-1:0]  next_trial;
    int                code_off;

    // Bias tracks code combinationally so both move in the same timestep.
    assign code_off = int'(code) - MID;
    assign biasp    = VCM + $itor(code_off) * LSB / 2.0;
    assign biasn    = VCM - $itor(code_off) * LSB / 2.0;

    assign cal_busy = (state == SETTLE) || (state == SAMPLE) || (state == DECIDE);
    assign cal_done = (state == DONE);
    assign idx_m1   = idx - 1'b1;

    // A strict majority of positive samples means the trial code is too high; a tie keeps it.
    always_comb begin
        decided_code = code;
        if (votes > HALF_VOTES) decided_code[idx] = 1'b0;
        next_trial = decided_code;
        if (idx != '0) next_trial[idx_m1] = 1'b1;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state  <= IDLE;
            code   <= MID_CODE;
            result <= MID_CODE;
            idx    <= '0;
            cnt    <= '0;
            votes  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cal_en) begin
                        code  <= MID_CODE;
                        idx   <= IDX_MSB;
                        cnt   <= '0;
                        votes <= '0;
                        state <= SETTLE;
                    end
                end
                SETTLE, SAMPLE, DECIDE: begin
                    if (!cal_en) begin
                        // Abort discards the partial search and restores the last good code.
                        code  <= result;
                        cnt   <= '0;
                        votes <= '0;
                        state <= IDLE;
                    end else if (state == SETTLE) begin
                        if (cnt == SETTLE_LAST) begin
                            cnt   <= '0;
                            state <= SAMPLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (state == SAMPLE) begin
                        if (outp > outn) votes <= votes + 1'b1;
                        if (cnt == SAMPLE_LAST) begin
                            cnt   <= '0;
                            state <= DECIDE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (idx == '0) begin
                        code   <= decided_code;
                        result <= decided_code;
                        state  <= DONE;
                    end else begin
                        code  <= next_trial;
                        idx   <= idx_m1;
                        cnt   <= '0;
                        votes <= '0;
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    if (!cal_en) begin
                        code  <= result;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
